// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting sequencer.
package time_set_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MINUTE_W = 6;

  localparam int unsigned HOUR_MAX_DEFAULT = 23;
  localparam int unsigned MINUTE_MAX_DEFAULT = 59;

  typedef enum logic [1:0] {
    StIdle,
    StEditHour,
    StEditMin,
    StCommit
  } state_e;

endpackage

// File: rtl/time_set_controller_if.sv
// Set-time bus between the time-setting sequencer (master) and the hour/minute counters (slave).
interface time_set_controller_if;
  import time_set_pkg::*;

  logic                set_time_en;
  logic [HOUR_W-1:0]   set_time_hour;
  logic [MINUTE_W-1:0] set_time_minute;
  logic [HOUR_W-1:0]   cur_hour;
  logic [MINUTE_W-1:0] cur_minute;

  modport master (
    output set_time_en,
    output set_time_hour,
    output set_time_minute,
    input  cur_hour,
    input  cur_minute
  );

  modport slave (
    input  set_time_en,
    input  set_time_hour,
    input  set_time_minute,
    output cur_hour,
    output cur_minute
  );

endinterface

// File: rtl/time_set_field.sv
// One editable time field: clamped load, then up/down adjust with explicit wrap at 0 and MaxVal.
module time_set_field #(
  parameter int unsigned Width  = 5,
  parameter int unsigned MaxVal = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] value
);

  localparam logic [Width-1:0] Max = Width'(MaxVal);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (load_value > Max) ? Max : load_value;
    end else if (en && inc && !dec) begin
      value_d = (value_q >= Max) ? '0 : value_q + Width'(1);
    end else if (en && dec && !inc) begin
      value_d = (value_q == '0) ? Max : value_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/time_set_controller.sv
// Button-driven hour/minute editor issuing a one-cycle set-time load to the counters.
// Optional inactivity abort is enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int unsigned HOUR_MAX       = HOUR_MAX_DEFAULT,
  parameter int unsigned MINUTE_MAX     = MINUTE_MAX_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_mode,
  input  logic                  btn_up,
  input  logic                  btn_down,
  time_set_controller_if.master ts,
  output logic                  edit_hour,
  output logic                  edit_minute,
  output logic                  busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e              state_q;
  logic                set_time_en_q;
  logic [HOUR_W-1:0]   set_time_hour_q;
  logic [MINUTE_W-1:0] set_time_minute_q;
  logic                edit_hour_q, edit_minute_q, busy_q;

  logic [HOUR_W-1:0]   hour_val;
  logic [MINUTE_W-1:0] minute_val;
  logic                capture;
  logic                timeout_hit;

  // Capture live time on edit entry; mode in the same cycle suppresses any adjust.
  assign capture = (state_q == StIdle) && btn_mode;

  time_set_field #(
    .Width  (HOUR_W),
    .MaxVal (HOUR_MAX)
  ) u_hour_field (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         ((state_q == StEditHour) && !btn_mode),
    .load       (capture),
    .load_value (ts.cur_hour),
    .inc        (btn_up),
    .dec        (btn_down),
    .value      (hour_val)
  );

  time_set_field #(
    .Width  (MINUTE_W),
    .MaxVal (MINUTE_MAX)
  ) u_minute_field (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         ((state_q == StEditMin) && !btn_mode),
    .load       (capture),
    .load_value (ts.cur_minute),
    .inc        (btn_up),
    .dec        (btn_down),
    .value      (minute_val)
  );

`ifdef TIME_SET_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q;
  logic            any_btn;

  assign any_btn     = btn_mode | btn_up | btn_down;
  assign timeout_hit = !any_btn && (tmo_q == TmoLast);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      set_time_en_q     <= 1'b0;
      set_time_hour_q   <= '0;
      set_time_minute_q <= '0;
      edit_hour_q       <= 1'b0;
      edit_minute_q     <= 1'b0;
      busy_q            <= 1'b0;
`ifdef TIME_SET_TIMEOUT_EN
      tmo_q             <= '0;
`endif
    end else begin
      set_time_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn_mode) begin
            state_q     <= StEditHour;
            edit_hour_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StEditHour: begin
          if (btn_mode) begin
            state_q       <= StEditMin;
            edit_hour_q   <= 1'b0;
            edit_minute_q <= 1'b1;
          end else if (timeout_hit) begin
            state_q     <= StIdle;
            edit_hour_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        StEditMin: begin
          if (btn_mode) begin
            state_q           <= StCommit;
            edit_minute_q     <= 1'b0;
            set_time_en_q     <= 1'b1;
            set_time_hour_q   <= hour_val;
            set_time_minute_q <= minute_val;
          end else if (timeout_hit) begin
            state_q       <= StIdle;
            edit_minute_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        StCommit: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
`ifdef TIME_SET_TIMEOUT_EN
      // Count idle cycles only while editing; any button or leaving edit restarts it.
      if ((state_q == StEditHour || state_q == StEditMin) && !any_btn && !timeout_hit) begin
        tmo_q <= tmo_q + TmoW'(1);
      end else begin
        tmo_q <= '0;
      end
`endif
    end
  end

  assign ts.set_time_en     = set_time_en_q;
  assign ts.set_time_hour   = set_time_hour_q;
  assign ts.set_time_minute = set_time_minute_q;
  assign edit_hour          = edit_hour_q;
  assign edit_minute        = edit_minute_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller; timeout checks run when TIME_SET_TIMEOUT_EN is defined.
module tb_time_set_controller;

  logic clk;
  logic rst_n;
  logic btn_mode, btn_up, btn_down;
  logic edit_hour, edit_minute, busy;

  int n_cmp;
  int n_err;
  int en_count;

  time_set_controller_if ts ();

  time_set_controller #(
    .HOUR_MAX       (23),
    .MINUTE_MAX     (59),
    .TIMEOUT_CYCLES (30)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .ts          (ts.master),
    .edit_hour   (edit_hour),
    .edit_minute (edit_minute),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ts.set_time_en === 1'b1) en_count++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge: holds the buttons across one posedge, returns at the next negedge.
  task automatic press(input logic m, input logic u, input logic d);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic set_cur(input int unsigned h, input int unsigned m);
    ts.cur_hour   = 5'(h);
    ts.cur_minute = 6'(m);
  endtask

  initial begin
    int base;
    n_cmp    = 0;
    n_err    = 0;
    en_count = 0;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    set_cur(0, 0);

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_en", ts.set_time_en, 0);
    check("rst_hour", ts.set_time_hour, 0);
    check("rst_minute", ts.set_time_minute, 0);
    check("rst_edit_hour", edit_hour, 0);
    check("rst_edit_minute", edit_minute, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle ignores up/down
    press(0, 1, 0);
    press(0, 1, 0);
    check("idle_busy", busy, 0);
    check("idle_hour", ts.set_time_hour, 0);
    check("idle_en_count", en_count, 0);

    // 10:45 -> 13:43
    set_cur(10, 45);
    press(1, 0, 0);
    check("enter_edit_hour", edit_hour, 1);
    check("enter_busy", busy, 1);
    set_cur(5, 5);
    repeat (3) press(0, 1, 0);
    press(1, 0, 0);
    check("adv_edit_minute", edit_minute, 1);
    check("adv_edit_hour", edit_hour, 0);
    repeat (2) press(0, 0, 1);
    check("pre_commit_en", ts.set_time_en, 0);
    press(1, 0, 0);
    check("commit1_en", ts.set_time_en, 1);
    check("commit1_hour", ts.set_time_hour, 13);
    check("commit1_minute", ts.set_time_minute, 43);
    check("commit1_edit_minute", edit_minute, 0);
    @(negedge clk);
    check("post1_en", ts.set_time_en, 0);
    check("post1_busy", busy, 0);
    check("post1_hold_hour", ts.set_time_hour, 13);
    check("post1_en_count", en_count, 1);

    // Wrap both fields: 23:00 -> 0:59
    set_cur(23, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    check("wrap_hour", ts.set_time_hour, 0);
    check("wrap_minute", ts.set_time_minute, 59);

    // Out-of-range capture clamps; mode pressed during commit is ignored
    @(negedge clk);
    set_cur(31, 63);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("clamp_en", ts.set_time_en, 1);
    check("clamp_hour", ts.set_time_hour, 23);
    check("clamp_minute", ts.set_time_minute, 59);
    press(1, 0, 0);
    check("commit_ignore_busy", busy, 0);
    check("commit_ignore_edit", edit_hour, 0);

    // Priority: mode beats up, up+down is a no-op
    set_cur(7, 20);
    press(1, 0, 0);
    press(0, 1, 1);
    press(1, 1, 0);
    check("prio_edit_minute", edit_minute, 1);
    press(0, 1, 1);
    press(0, 0, 1);
    press(1, 0, 0);
    check("prio_hour", ts.set_time_hour, 7);
    check("prio_minute", ts.set_time_minute, 19);
    @(negedge clk);

    // Reset while editing minutes: immediate clear, no commit afterwards
    base = en_count;
    set_cur(3, 4);
    press(1, 0, 0);
    press(1, 0, 0);
    check("mid_edit_minute", edit_minute, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_edit_minute", edit_minute, 0);
    check("midrst_busy", busy, 0);
    check("midrst_hour", ts.set_time_hour, 0);
    check("midrst_minute", ts.set_time_minute, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_commit", en_count, base);
    check("midrst_idle", busy, 0);

`ifdef TIME_SET_TIMEOUT_EN
    // Abandon after 30 quiet cycles
    base = en_count;
    press(1, 0, 0);
    repeat (29) @(negedge clk);
    check("tmo_still_busy", busy, 1);
    @(negedge clk);
    check("tmo_busy", busy, 0);
    check("tmo_edit_hour", edit_hour, 0);
    check("tmo_no_commit", en_count, base);

    // A button in the 29th quiet cycle restarts the count
    press(1, 0, 0);
    repeat (28) @(negedge clk);
    press(0, 1, 0);
    check("tmo_restart_busy", busy, 1);
    repeat (29) @(negedge clk);
    check("tmo_restart_still", busy, 1);
    @(negedge clk);
    check("tmo_restart_expire", busy, 0);
    check("tmo_restart_no_commit", en_count, base);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
